// File: rtl/circuit_misr_if.sv
// Response handshake between the circuit's out[] bus and the MISR checker.
// CIRCUIT_MISR_XMASK_EN adds the per-vector don't-care mask.
interface circuit_misr_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] expected;
`ifdef CIRCUIT_MISR_XMASK_EN
  logic [WIDTH-1:0] xmask;

  modport master (output in_valid, output in_data, output expected, output xmask, input in_ready);
  modport slave  (input in_valid, input in_data, input expected, input xmask, output in_ready);
`else
  modport master (output in_valid, output in_data, output expected, input in_ready);
  modport slave  (input in_valid, input in_data, input expected, output in_ready);
`endif
endinterface

// File: rtl/circuit_misr_checker.sv
// MISR response compactor: folds VEC_COUNT accepted vectors into a Galois
// signature and compares the result with a golden value.
// Optional feature macro: CIRCUIT_MISR_XMASK_EN (masks don't-care bits of in_data).
module circuit_misr_checker #(
  parameter int unsigned      WIDTH     = 5,
  parameter int unsigned      VEC_COUNT = 32,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(5'b00101),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(5'b00000),
  localparam int unsigned     CW        = $clog2(VEC_COUNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  circuit_misr_if.slave       bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [WIDTH-1:0]    signature,
  output logic [CW-1:0]       count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] fold_data;
  logic [WIDTH-1:0] nxt;
  logic             accept;
  logic             last;

  // Next signature for the vector on the bus (masked when the feature is built in)
  always_comb begin
`ifdef CIRCUIT_MISR_XMASK_EN
    fold_data = bus.in_data & ~bus.xmask;
`else
    fold_data = bus.in_data;
`endif
    nxt    = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ fold_data;
    accept = ready_q & bus.in_valid;
    last   = (count_q == CW'(VEC_COUNT - 1));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    count_d = count_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d   = nxt;
          count_d = CW'(count_q + CW'(1));
          if (last) begin
            state_d = S_DONE;
            pass_d  = (nxt == bus.expected);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d == S_RUN);
    ready_d = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      count_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign count        = count_q;

endmodule
